sdram_loader: RTL

- Streams a byte sequence from the MCU/SPI side into SDRAM as 16-bit word writes.
- Acts as the upstream master on one sdram_bus channel of the SDRAM controller, normally ch2, the lowest priority.
- Packs bytes little-endian, auto-increments the word address, buffers packed words in a small FIFO and issues toggle-handshake write requests.
- Used to load cartridge ROM/CHR images before and during play.

---
 rtl/sdram_pkg.sv | 10 +
 rtl/sdram_bus.sv | 32 +++
 rtl/sync_fifo.sv | 108 ++++++++++
 rtl/sdram_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM-side types and constants used by the loader and its slice.
package sdram_pkg;

    typedef shortint unsigned uint16;
    typedef logic [15:0]      sdram_word_t;

    // Filler for the high byte when a load has an odd byte count.
    localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/sdram_bus.sv
// One channel of the SDRAM controller: toggle-handshake request/ack plus
// address and write/read data. A request is outstanding while req != ack.
interface sdram_bus #(
    parameter int ADDR_BITS = 22
) ();

    logic                 req;
    logic                 ack;
    logic [ADDR_BITS-1:0] address;
    logic                 we;
    logic [15:0]          data_write;
    logic [15:0]          data_read;

    modport master (
        output req,
        output address,
        output we,
        output data_write,
        input  ack,
        input  data_read
    );

    modport slave (
        input  req,
        input  address,
        input  we,
        input  data_write,
        output ack,
        output data_read
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with synchronous active-high reset. The head entry
// is always presented on 'head' straight from the storage flops, so a pop
// and the use of its data happen in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_COUNT = (AW+1)'(0);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full FIFO or a pop from an empty one is dropped so the
    // occupancy count can never wrap, even if a caller misbehaves.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (push && !full) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop in one cycle both take effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_COUNT;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates their use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == ZERO_COUNT);

    sync_fifo_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .full  (full),
        .empty (empty)
    );

endmodule

// Simulation-only protocol checks for sync_fifo callers.
module sync_fifo_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    // The caller gates pushes with its own ready, so a full FIFO never sees one.
    push_when_full_a: assert property (@(posedge clk) disable iff (reset) !(push && full));

    // The issuer only pops a non-empty FIFO.
    pop_when_empty_a: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/sdram_loader.sv
// Byte-stream to SDRAM word loader. Bytes are packed little-endian into
// 16-bit words at auto-incrementing word addresses, queued in a small FIFO,
// and written out over one sdram_bus channel using the toggle handshake.
module sdram_loader
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS  = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sdram_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   byte_count,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    sdram_bus.master             ch
);

    localparam int ENTRY_W = ADDR_BITS + 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_BITS:0]   ZERO_COUNT = (ADDR_BITS+1)'(0);
    localparam logic [ADDR_BITS:0]   ONE_COUNT  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO  = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

    // Control state
    logic [1:0]           state_r;
    logic [ADDR_BITS-1:0] addr_cnt_r;
    logic [ADDR_BITS:0]   remaining_r;
    logic [7:0]           lo_byte_r;
    logic                 odd_r;          // a low byte is waiting for its partner
    logic                 busy_r;
    logic                 done_r;

    // Issuer state. req_r is deliberately left out of reset: it must keep
    // agreeing with the slave's ack, which a mid-operation reset does not
    // touch. Its power-up value matches the slave's ack power-up value.
    logic                 req_r = 1'b0;
    logic [ADDR_BITS-1:0] address_r;
    sdram_word_t          data_r;

    // Datapath / handshake signals
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 last_byte_s;
    sdram_word_t          push_word_s;
    logic                 fifo_push_s;
    logic                 fifo_pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [ENTRY_W-1:0]   fifo_head_s;
    logic [ENTRY_W-1:0]   push_entry_s;
    logic                 unused_read;

    // Byte acceptance, word packing and FIFO push/pop decisions.
    always_comb begin
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        last_byte_s  = 1'b0;
        push_word_s  = 16'h0000;
        fifo_push_s  = 1'b0;
        fifo_pop_s   = 1'b0;
        push_entry_s = {ENTRY_W{1'b0}};

        if ((state_r == ST_LOAD) && !fifo_full_s && (remaining_r != ZERO_COUNT)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end

        accept_s    = in_valid && in_ready_s;
        last_byte_s = (remaining_r == ONE_COUNT);

        // An odd-numbered byte completes the word; a lone final even byte is padded.
        if (odd_r) begin
            push_word_s = {in_data, lo_byte_r};
        end else begin
            push_word_s = {PAD_BYTE, in_data};
        end

        fifo_push_s  = accept_s && (odd_r || last_byte_s);
        push_entry_s = {addr_cnt_r, push_word_s};

        // Issue only when nothing is outstanding; nothing new starts during reset.
        if (!reset && !fifo_empty_s && (req_r == ch.ack)) begin
            fifo_pop_s = 1'b1;
        end else begin
            fifo_pop_s = 1'b0;
        end
    end

    // Load sequencing: IDLE -> LOAD -> FLUSH -> DONE -> IDLE, plus the byte packer.
    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_cnt_r  <= ADDR_ZERO;
            remaining_r <= ZERO_COUNT;
            lo_byte_r   <= 8'h00;
            odd_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_cnt_r  <= base_addr;
                        remaining_r <= byte_count;
                        odd_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        if (byte_count == ZERO_COUNT) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        remaining_r <= remaining_r - ONE_COUNT;
                        if (fifo_push_s) begin
                            odd_r      <= 1'b0;
                            addr_cnt_r <= addr_cnt_r + ADDR_ONE;
                        end else begin
                            odd_r     <= 1'b1;
                            lo_byte_r <= in_data;
                        end
                        if (last_byte_s) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty_s && (req_r == ch.ack)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Request issuer: pop the head, present it and toggle req in one step; held until acked.
    always_ff @(posedge sdram_clk) begin
        if (fifo_pop_s) begin
            req_r     <= !req_r;
            address_r <= fifo_head_s[ENTRY_W-1:16];
            data_r    <= fifo_head_s[15:0];
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sdram_clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (push_entry_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign in_ready      = in_ready_s;
    assign busy          = busy_r;
    assign done          = done_r;
    assign ch.req        = req_r;
    assign ch.address    = address_r;
    assign ch.data_write = data_r;
    assign ch.we         = 1'b1;

    // Read data is never used by a write-only master.
    assign unused_read = ^ch.data_read;

endmodule
